// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Boot loader for an RV32I core's instruction memory.
//   Program words arrive one at a time over a valid/ready handshake.
//   Each accepted word is written to memory as four bytes, least
//   significant byte first, on four consecutive cycles. The core is held
//   in reset until the word flagged last has been written, and is then
//   released. A reload pulse while the core runs starts a new load from
//   address 0. A program that would run past the end of memory parks the
//   block in ERR, which only reset clears.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous active-low reset
//   load_valid  a program word is offered
//   load_data   32-bit instruction word, little-endian
//   load_last   offered word is the final program word
//   load_ready  block can accept a word this cycle
//   reload      one-cycle pulse requesting a new program load (RUN only)
//   mem_we      byte write strobe to instruction memory
//   mem_addr    byte address for the write
//   mem_wdata   byte data for the write
//   core_reset  active-high reset to the core, held high while loading
//   done        program loaded and core running
//   err         program overflowed the memory
//
// State | meaning
//   IDLE  | waiting for the next program word
//   WRITE | writing the captured word, one byte per cycle (byte_idx 0..3)
//   RUN   | program loaded, core released from reset
//   ERR   | program ran past the end of memory; only reset exits
module imem_boot_ctrl #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;

  // One extra bit so the end-of-memory compare cannot alias to address 0.
  logic [ADDR_W:0]   ptr_plus4;
  logic              at_end;

  assign ptr_plus4 = {1'b0, ptr_q} + (ADDR_W+1)'(4);
  assign at_end    = (ptr_plus4 == (ADDR_W+1)'(DEPTH_BYTES));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    last_d     = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          word_d     = load_data;
          last_d     = load_last;
          byte_idx_d = 2'd0;
          state_d    = ST_WRITE;
        end
      end

      ST_WRITE: begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          byte_idx_d = 2'd0;
          if (last_q) begin
            ptr_d   = '0;
            state_d = ST_RUN;
          end else if (at_end) begin
            // Pointer is left on the last word; the address never wraps.
            state_d = ST_ERR;
          end else begin
            ptr_d   = ptr_plus4[ADDR_W-1:0];
            state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        if (reload) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
    end
  end

  // Outputs decode registered state only. The pointer is word-aligned, so
  // ptr + byte_idx is a plain concatenation with no carry.
  always_comb begin
    load_ready = (state_q == ST_IDLE);
    mem_we     = (state_q == ST_WRITE);
    core_reset = (state_q != ST_RUN);
    done       = (state_q == ST_RUN);
    err        = (state_q == ST_ERR);
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    if (state_q == ST_WRITE) begin
      mem_addr = {ptr_q[ADDR_W-1:2], byte_idx_q};
      unique case (byte_idx_q)
        2'd0: mem_wdata = word_q[7:0];
        2'd1: mem_wdata = word_q[15:8];
        2'd2: mem_wdata = word_q[23:16];
        2'd3: mem_wdata = word_q[31:24];
        default: mem_wdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, 256 bytes
  logic        reset, load_valid, load_last, reload;
  logic [31:0] load_data;
  logic        load_ready, mem_we, core_reset, done, err;
  logic [7:0]  mem_addr, mem_wdata;

  // Small instance, 8 bytes, for overflow
  logic        rst8, lv8, ll8, rl8;
  logic [31:0] ld8;
  logic        lr8, we8, cr8, dn8, er8;
  logic [2:0]  addr8;
  logic [7:0]  wd8;

  imem_boot_ctrl #(.DEPTH_BYTES(256)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .done(done), .err(err));

  imem_boot_ctrl #(.DEPTH_BYTES(8)) dut8 (
    .clk(clk), .reset(rst8), .load_valid(lv8), .load_data(ld8),
    .load_last(ll8), .load_ready(lr8), .reload(rl8),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
    .core_reset(cr8), .done(dn8), .err(er8));

  int checks = 0;
  int errors = 0;

  // Reference model: next word address and expected memory image.
  int         model_ptr;
  logic [7:0] exp_mem [0:255];

  // Memory image as actually written by the main DUT.
  logic [7:0] dut_mem [0:255];
  int         wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      dut_mem[mem_addr] <= mem_wdata;
      wr_cnt            <= wr_cnt + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
        core_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0h wd=%0h cr=%b dn=%b er=%b want 1 0 0 0 1 0 0",
               load_ready, mem_we, mem_addr, mem_wdata, core_reset, done, err);
    end
    reset = 1'b1;
    model_ptr = 0;
  endtask

  // Offer one word at the current negedge (block expected in IDLE) and
  // check the four byte writes plus the state that follows.
  task automatic offer_word(input logic [31:0] w, input logic last, input bit junk);
    reload = 1'b0;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready: got load_ready=%b want 1", load_ready);
    end
    load_valid = 1'b1; load_data = w; load_last = last;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'(model_ptr + i) || mem_wdata !== w[8*i +: 8] ||
          load_ready !== 1'b0 || core_reset !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL write_byte%0d: got we=%b addr=%0h wd=%0h rdy=%b cr=%b dn=%b want 1 %0h %0h 0 1 0",
                 i, mem_we, mem_addr, mem_wdata, load_ready, core_reset, done,
                 8'(model_ptr + i), w[8*i +: 8]);
      end
      exp_mem[model_ptr + i] = w[8*i +: 8];
      if (junk) begin
        load_valid = 1'($urandom_range(0, 1));
        load_data  = $urandom;
        load_last  = 1'($urandom_range(0, 1));
        reload     = 1'($urandom_range(0, 1));
      end else begin
        load_valid = 1'b0;
        reload     = 1'b0;
      end
    end
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0; reload = 1'b0;
    checks++;
    if (last) begin
      model_ptr = 0;
      if (done !== 1'b1 || core_reset !== 1'b0 || load_ready !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL after_last: got dn=%b cr=%b rdy=%b we=%b er=%b want 1 0 0 0 0",
                 done, core_reset, load_ready, mem_we, err);
      end
    end else begin
      model_ptr += 4;
      if (done !== 1'b0 || core_reset !== 1'b1 || load_ready !== 1'b1 || mem_we !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL after_word: got dn=%b cr=%b rdy=%b we=%b er=%b want 0 1 1 0 0",
                 done, core_reset, load_ready, mem_we, err);
      end
    end
  endtask

  task automatic idle_gap(input int n);
    for (int g = 0; g < n; g++) begin
      checks++;
      if (load_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || core_reset !== 1'b1) begin
        errors++;
        $display("FAIL idle_gap: got rdy=%b we=%b dn=%b cr=%b want 1 0 0 1",
                 load_ready, mem_we, done, core_reset);
      end
      load_valid = 1'b0;
      reload = 1'($urandom_range(0, 1));  // ignored in IDLE
      @(negedge clk);
    end
    reload = 1'b0;
  endtask

  task automatic check_image(input int nbytes, input string name);
    for (int a = 0; a < nbytes; a++) begin
      checks++;
      if (dut_mem[a] !== exp_mem[a]) begin
        errors++;
        $display("FAIL %s image[%0d]: got %0h want %0h", name, a, dut_mem[a], exp_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_word();
    do_reset();
    offer_word(32'h01000093, 1'b1, 1'b0);
    check_image(4, "single");
  endtask

  task automatic test_program();
    logic [31:0] prog [6];
    int start_cnt;
    prog = '{32'h01000093, 32'h01008113, 32'h401101B3, 32'h00119233, 32'h0030A023, 32'h0000A283};
    do_reset();
    start_cnt = wr_cnt;
    for (int k = 0; k < 6; k++) begin
      idle_gap($urandom_range(1, 3));
      offer_word(prog[k], 1'(k == 5), 1'b1);
    end
    check_image(24, "program");
    checks++;
    if (wr_cnt - start_cnt !== 24) begin
      errors++;
      $display("FAIL program_write_count: got %0d want 24", wr_cnt - start_cnt);
    end
  endtask

  task automatic test_random_program();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 10);
      do_reset();
      for (int k = 0; k < n; k++) begin
        idle_gap($urandom_range(0, 2));
        offer_word($urandom, 1'(k == n - 1), 1'($urandom_range(0, 1)));
      end
      check_image(4 * n, "random");
    end
  endtask

  task automatic test_reload();
    // block is in RUN from the previous test
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checks++;
    if (core_reset !== 1'b1 || load_ready !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reload_idle: got cr=%b rdy=%b dn=%b we=%b want 1 1 0 0",
               core_reset, load_ready, done, mem_we);
    end
    model_ptr = 0;
    offer_word(32'hA5C3_5A3C, 1'b1, 1'b0);
    check_image(4, "reload");
  endtask

  task automatic test_reset_mid_write();
    int start_cnt;
    do_reset();
    offer_word(32'h11223344, 1'b0, 1'b0);
    start_cnt = wr_cnt;
    load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);  // byte 1 cycle
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h05) begin
      errors++;
      $display("FAIL midwrite_byte1: got we=%b addr=%0h want 1 5", mem_we, mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || load_ready !== 1'b1 || core_reset !== 1'b1 || mem_addr !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_abort: got we=%b rdy=%b cr=%b addr=%0h dn=%b want 0 1 1 0 0",
               mem_we, load_ready, core_reset, mem_addr, done);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_cnt - start_cnt !== 2) begin
      errors++;
      $display("FAIL midwrite_count: got %0d writes want 2", wr_cnt - start_cnt);
    end
    model_ptr = 0;
    offer_word(32'hCAFEF00D, 1'b1, 1'b0);
    check_image(4, "after_abort");
  endtask

  task automatic test_overflow();
    logic [31:0] wv [2];
    wv = '{32'h0badcafe, 32'h76543210};
    @(negedge clk);
    rst8 = 1'b0; lv8 = 1'b0; ld8 = '0; ll8 = 1'b0; rl8 = 1'b0;
    repeat (2) @(negedge clk);
    rst8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lr8 !== 1'b1) begin
        errors++;
        $display("FAIL ovf_ready%0d: got %b want 1", k, lr8);
      end
      lv8 = 1'b1; ld8 = wv[k]; ll8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        lv8 = 1'b0;
        rl8 = (i == 1);  // ignored in WRITE
        checks++;
        if (we8 !== 1'b1 || addr8 !== 3'(4 * k + i) || wd8 !== wv[k][8*i +: 8] || lr8 !== 1'b0) begin
          errors++;
          $display("FAIL ovf_write%0d_%0d: got we=%b addr=%0h wd=%0h rdy=%b want 1 %0h %0h 0",
                   k, i, we8, addr8, wd8, lr8, 3'(4 * k + i), wv[k][8*i +: 8]);
        end
      end
      @(negedge clk);
      rl8 = 1'b0;
    end
    checks++;
    if (er8 !== 1'b1 || cr8 !== 1'b1 || lr8 !== 1'b0 || we8 !== 1'b0 || dn8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err: got er=%b cr=%b rdy=%b we=%b dn=%b want 1 1 0 0 0", er8, cr8, lr8, we8, dn8);
    end
    lv8 = 1'b1; ld8 = 32'hFFFFFFFF; ll8 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rl8 = (c == 3);
      @(negedge clk);
      checks++;
      if (er8 !== 1'b1 || we8 !== 1'b0 || lr8 !== 1'b0 || dn8 !== 1'b0) begin
        errors++;
        $display("FAIL ovf_stuck%0d: got er=%b we=%b rdy=%b dn=%b want 1 0 0 0", c, er8, we8, lr8, dn8);
      end
    end
    lv8 = 1'b0; rl8 = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
    rst8 = 1'b0; lv8 = 1'b0; ld8 = '0; ll8 = 1'b0; rl8 = 1'b0;
    for (int a = 0; a < 256; a++) exp_mem[a] = 8'h00;
    test_reset();
    test_single_word();
    test_program();
    test_random_program();
    test_reload();
    test_reset_mid_write();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
